// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: pipeline stall/flush and forwarding control; define HAZ_PERF_CNT_EN for per-cause cycle counters
module hazard_fwd_unit #(
  parameter int AW = 5,
  parameter int MDU_LAT = 4,
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  input  logic          id_use_rs,
  input  logic          id_use_rt,
  input  logic          id_mdu_start,
  input  logic          id_hilo_use,
  input  logic [AW-1:0] ex_rd,
  input  logic          ex_reg_write,
  input  logic          ex_mem_to_reg,
  input  logic [AW-1:0] mem_rd,
  input  logic          mem_reg_write,
  input  logic          ex_branch_taken,
  input  logic          mem_wait,
  output logic          stall_if,
  output logic          stall_id,
  output logic          flush_ifid,
  output logic          flush_idex,
  output logic [1:0]    fwd_a,
  output logic [1:0]    fwd_b,
  output logic          mdu_busy,
`ifdef HAZ_PERF_CNT_EN
  output logic [CNT_W-1:0] cnt_ld,
  output logic [CNT_W-1:0] cnt_mdu,
  output logic [CNT_W-1:0] cnt_mem,
  output logic [CNT_W-1:0] cnt_flush,
`endif
  output logic [1:0]    haz_state
);
  typedef enum logic [1:0] {RUN, LDSTALL, MDUSTALL, MEMWAIT} haz_t;
  haz_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic ld_haz, mdu_haz, w_br, w_mw, w_ld, w_mdu, issue;
  logic [1:0] fa_d, fb_d;
  // Hazard detection, priority resolution and next-state for forward/MDU/state registers
  always_comb begin
    ld_haz = ex_mem_to_reg && ex_reg_write && ex_rd != '0 &&
             ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
    mdu_haz = mdu_busy && (id_mdu_start || id_hilo_use);
    w_br = ex_branch_taken;
    w_mw = !w_br && mem_wait;
    w_ld = !w_br && !mem_wait && ld_haz;
    w_mdu = !w_br && !mem_wait && !ld_haz && mdu_haz;
    stall_if = w_mw || w_ld || w_mdu;
    stall_id = stall_if;
    flush_ifid = w_br;
    flush_idex = w_br || w_ld || w_mdu;
    issue = id_mdu_start && !mdu_busy && !stall_if && !flush_idex;
    cnt_d = issue ? 4'(MDU_LAT) : (cnt_q != '0) ? cnt_q - 4'd1 : cnt_q;
    fa_d = flush_idex ? 2'b00 :
           (ex_reg_write && ex_rd != '0 && id_rs == ex_rd && !ex_mem_to_reg) ? 2'b01 :
           (mem_reg_write && mem_rd != '0 && id_rs == mem_rd) ? 2'b10 : 2'b00;
    fb_d = flush_idex ? 2'b00 :
           (ex_reg_write && ex_rd != '0 && id_rt == ex_rd && !ex_mem_to_reg) ? 2'b01 :
           (mem_reg_write && mem_rd != '0 && id_rt == mem_rd) ? 2'b10 : 2'b00;
    state_d = w_mw ? MEMWAIT : w_ld ? LDSTALL : w_mdu ? MDUSTALL : RUN;
  end
  // Forward selects freeze while memory stalls; MDU countdown and cause tracking run every cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_a <= 2'b00;
      fwd_b <= 2'b00;
      cnt_q <= '0;
      state_q <= RUN;
    end else begin
      if (!mem_wait) begin
        fwd_a <= fa_d;
        fwd_b <= fb_d;
      end
      cnt_q <= cnt_d;
      state_q <= state_d;
    end
  end
  assign mdu_busy = cnt_q != '0;
  assign haz_state = state_q;
`ifdef HAZ_PERF_CNT_EN
  // Saturating count of cycles won by each cause
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_ld <= '0;
      cnt_mdu <= '0;
      cnt_mem <= '0;
      cnt_flush <= '0;
    end else begin
      if (w_ld && !(&cnt_ld)) cnt_ld <= cnt_ld + 1'b1;
      if (w_mdu && !(&cnt_mdu)) cnt_mdu <= cnt_mdu + 1'b1;
      if (w_mw && !(&cnt_mem)) cnt_mem <= cnt_mem + 1'b1;
      if (w_br && !(&cnt_flush)) cnt_flush <= cnt_flush + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb_hazard_fwd_unit: directed vector table plus MDU, mem-wait and async-reset sequences
module tb_hazard_fwd_unit;
  logic clk = 0, rst = 1;
  logic [4:0] id_rs, id_rt, ex_rd, mem_rd;
  logic id_use_rs, id_use_rt, id_mdu_start, id_hilo_use;
  logic ex_reg_write, ex_mem_to_reg, mem_reg_write, ex_branch_taken, mem_wait;
  logic stall_if, stall_id, flush_ifid, flush_idex, mdu_busy;
  logic [1:0] fwd_a, fwd_b, haz_state;
`ifdef HAZ_PERF_CNT_EN
  logic [15:0] cnt_ld, cnt_mdu, cnt_mem, cnt_flush;
`endif
  int errs = 0, total = 0;

  hazard_fwd_unit dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_mdu_start(id_mdu_start), .id_hilo_use(id_hilo_use), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_to_reg(ex_mem_to_reg), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .ex_branch_taken(ex_branch_taken), .mem_wait(mem_wait), .stall_if(stall_if), .stall_id(stall_id),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex), .fwd_a(fwd_a), .fwd_b(fwd_b), .mdu_busy(mdu_busy),
`ifdef HAZ_PERF_CNT_EN
    .cnt_ld(cnt_ld), .cnt_mdu(cnt_mdu), .cnt_mem(cnt_mem), .cnt_flush(cnt_flush),
`endif
    .haz_state(haz_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs, rt; logic urs, urt;
    logic [4:0] exrd; logic exrw, exm2r;
    logic [4:0] memrd; logic memrw, br, mw;
    logic [3:0] comb;
    logic [1:0] fa, fb, st;
  } vec_t;
  vec_t v[12];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_in();
    id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0; id_mdu_start = 0; id_hilo_use = 0;
    ex_rd = 0; ex_reg_write = 0; ex_mem_to_reg = 0; mem_rd = 0; mem_reg_write = 0;
    ex_branch_taken = 0; mem_wait = 0;
  endtask

  initial begin
    // rs rt urs urt | exrd exrw exm2r | memrd memrw | br mw | {sif,sid,fifid,fidex} fa fb st
    v[0]  = '{5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 4'b0000, 2'b00, 2'b00, 2'd0};
    v[1]  = '{5'd1, 5'd3, 1, 1, 5'd3, 1, 0, 5'd3, 1, 0, 0, 4'b0000, 2'b00, 2'b01, 2'd0};
    v[2]  = '{5'd1, 5'd3, 1, 1, 5'd0, 1, 0, 5'd0, 1, 0, 0, 4'b0000, 2'b00, 2'b00, 2'd0};
    v[3]  = '{5'd5, 5'd0, 1, 0, 5'd0, 0, 0, 5'd5, 1, 0, 0, 4'b0000, 2'b10, 2'b00, 2'd0};
    v[4]  = '{5'd1, 5'd3, 1, 1, 5'd3, 1, 0, 5'd0, 0, 0, 1, 4'b1100, 2'b10, 2'b00, 2'd3};
    v[5]  = '{5'd2, 5'd7, 1, 1, 5'd2, 1, 1, 5'd0, 0, 0, 0, 4'b1101, 2'b00, 2'b00, 2'd1};
    v[6]  = '{5'd2, 5'd7, 1, 1, 5'd0, 0, 0, 5'd2, 1, 0, 0, 4'b0000, 2'b10, 2'b00, 2'd0};
    v[7]  = '{5'd2, 5'd7, 1, 1, 5'd2, 1, 1, 5'd0, 0, 0, 1, 4'b1100, 2'b10, 2'b00, 2'd3};
    v[8]  = '{5'd2, 5'd0, 0, 0, 5'd2, 1, 1, 5'd0, 0, 0, 0, 4'b0000, 2'b00, 2'b00, 2'd0};
    v[9]  = '{5'd1, 5'd4, 0, 1, 5'd4, 1, 1, 5'd0, 0, 0, 0, 4'b1101, 2'b00, 2'b00, 2'd1};
    v[10] = '{5'd2, 5'd2, 1, 1, 5'd2, 1, 1, 5'd2, 1, 1, 0, 4'b0011, 2'b00, 2'b00, 2'd0};
    v[11] = '{5'd6, 5'd0, 1, 1, 5'd6, 0, 0, 5'd6, 1, 0, 0, 4'b0000, 2'b10, 2'b00, 2'd0};
    clear_in();
    #2;
    chk("reset_fwd_a", 16'(fwd_a), 16'h0);
    chk("reset_fwd_b", 16'(fwd_b), 16'h0);
    chk("reset_busy", 16'(mdu_busy), 16'h0);
    chk("reset_state", 16'(haz_state), 16'h0);
    @(negedge clk); rst = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      id_rs = v[i].rs; id_rt = v[i].rt; id_use_rs = v[i].urs; id_use_rt = v[i].urt;
      ex_rd = v[i].exrd; ex_reg_write = v[i].exrw; ex_mem_to_reg = v[i].exm2r;
      mem_rd = v[i].memrd; mem_reg_write = v[i].memrw; ex_branch_taken = v[i].br; mem_wait = v[i].mw;
      #1 chk($sformatf("v%0d_stall_flush", i), 16'({stall_if, stall_id, flush_ifid, flush_idex}), 16'(v[i].comb));
      @(posedge clk); #1;
      chk($sformatf("v%0d_fwd_a", i), 16'(fwd_a), 16'(v[i].fa));
      chk($sformatf("v%0d_fwd_b", i), 16'(fwd_b), 16'(v[i].fb));
      chk($sformatf("v%0d_state", i), 16'(haz_state), 16'(v[i].st));
    end
    // mult then mfhi: four stalled cycles, then released
    @(negedge clk); clear_in(); id_mdu_start = 1;
    #1 chk("mult_issue_nostall", 16'(stall_if), 16'h0);
    @(negedge clk); id_mdu_start = 0; id_hilo_use = 1;
    for (int i = 0; i < 4; i++) begin
      #1 chk($sformatf("mfhi_stall%0d", i), 16'({stall_if, flush_idex, mdu_busy}), 16'b111);
      @(posedge clk); #1 chk($sformatf("mfhi_state%0d", i), 16'(haz_state), 16'h2);
      @(negedge clk);
    end
    #1 chk("mfhi_release", 16'({stall_if, mdu_busy}), 16'h0);
    // mem_wait during MDU countdown: forwarding holds, counter drains
    @(negedge clk); clear_in(); id_mdu_start = 1; id_rs = 5; id_use_rs = 1; mem_rd = 5; mem_reg_write = 1;
    @(negedge clk); clear_in(); mem_wait = 1; ex_rd = 1; ex_reg_write = 1; id_rs = 1;
    chk("mw_busy_start", 16'(mdu_busy), 16'h1);
    for (int i = 0; i < 4; i++) begin
      #1 chk($sformatf("mw_stall%0d", i), 16'({stall_if, stall_id, flush_idex}), 16'b110);
      @(posedge clk); #1 chk($sformatf("mw_fwd_a%0d", i), 16'(fwd_a), 16'h2);
      @(negedge clk);
    end
    chk("mw_busy_drained", 16'(mdu_busy), 16'h0);
    // async reset in LDSTALL with MDU busy
    clear_in(); id_mdu_start = 1;
    @(negedge clk); clear_in(); id_rs = 2; id_use_rs = 1; ex_rd = 2; ex_reg_write = 1; ex_mem_to_reg = 1;
    @(posedge clk); #1;
    chk("pre_rst_state", 16'({haz_state, mdu_busy}), 16'b011);
`ifdef HAZ_PERF_CNT_EN
    chk("pre_rst_cnt_ld_nz", 16'(cnt_ld != 0), 16'h1);
`endif
    #2 rst = 1;
    #1;
    chk("rst_state", 16'({haz_state, mdu_busy, fwd_a, fwd_b}), 16'h0);
    chk("rst_comb_stall", 16'({stall_if, flush_idex}), 16'b11);
`ifdef HAZ_PERF_CNT_EN
    chk("rst_cnts", 16'(cnt_ld | cnt_mdu | cnt_mem | cnt_flush), 16'h0);
`endif
    @(negedge clk); rst = 0; clear_in();
    $display("Result: errors=%0d of %0d checks", errs, total);
    $finish;
  end
endmodule
